// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared defaults, stage-count helper and configuration check for
//            the segmented pipelined adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    localparam int unsigned c_def_width = 32;
    localparam int unsigned c_def_seg   = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned seg);
        return width / seg;
    endfunction

    // WIDTH must be a positive whole number of SEG-bit segments.
    function automatic bit cfg_ok(input int unsigned width,
                                  input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ============================================================================
// Module   : adder_segment
// Brief    : Combinational SEG-bit ripple-carry slice built from full_adder.
// Revision : 1.0
// ============================================================================
module adder_segment
    import adder_pkg::*;
#(
    parameter int unsigned SEG = c_def_seg
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[SEG];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : Single-bit full adder cell.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : WIDTH-bit add/sub split into SEG-bit ripple segments, one register
//            stage per segment, valid/ready on both sides. Optional signed
//            overflow output when ADDER_OVERFLOW_EN is defined.
// Revision : 1.0
// ============================================================================
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = c_def_width,
    parameter int unsigned SEG   = c_def_seg
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             carryout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned STAGES = calc_stages(WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
    end

    logic             w_adv;
    op_e              w_op;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;

    // Index k is the input of stage k; index STAGES is the pipeline output.
    // Operands shift right by SEG per stage so the next segment is always in
    // the low bits; the result shifts in from the top.
    logic [WIDTH-1:0] w_a_src [STAGES+1];
    logic [WIDTH-1:0] w_b_src [STAGES+1];
    logic [WIDTH-1:0] w_r_src [STAGES+1];
    logic             w_c_src [STAGES+1];
    logic             w_v_src [STAGES+1];
`ifdef ADDER_OVERFLOW_EN
    logic             w_sa_src [STAGES+1];
    logic             w_sb_src [STAGES+1];
`endif

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_op   = op_e'(sub);
    assign w_beff = (w_op == OP_SUB) ? ~B   : B;
    assign w_c0   = (w_op == OP_SUB) ? ~Cin : Cin;

    assign w_a_src[0] = A;
    assign w_b_src[0] = w_beff;
    assign w_r_src[0] = '0;
    assign w_c_src[0] = w_c0;
    assign w_v_src[0] = in_valid;
`ifdef ADDER_OVERFLOW_EN
    assign w_sa_src[0] = A[WIDTH-1];
    assign w_sb_src[0] = w_beff[WIDTH-1];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]       w_sum;
        logic                 w_cout;
        logic [WIDTH+SEG-1:0] w_res_cat;
        logic [SEG-1:0]       w_unused_res;

        logic [WIDTH-1:0]     r_a;
        logic [WIDTH-1:0]     r_b;
        logic [WIDTH-1:0]     r_res;
        logic                 r_cy;
        logic                 r_vld;
`ifdef ADDER_OVERFLOW_EN
        logic                 r_sa;
        logic                 r_sb;
`endif

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (w_a_src[k][SEG-1:0]),
            .b    (w_b_src[k][SEG-1:0]),
            .cin  (w_c_src[k]),
            .s    (w_sum),
            .cout (w_cout)
        );

        // The low SEG bits of the concatenation are the initial zero-fill
        // bits that drop off the bottom as each segment result shifts in.
        assign w_res_cat    = {w_sum, w_r_src[k]};
        assign w_unused_res = w_res_cat[SEG-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_a   <= '0;
                r_b   <= '0;
                r_res <= '0;
                r_cy  <= 1'b0;
                r_vld <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
                r_sa  <= 1'b0;
                r_sb  <= 1'b0;
`endif
            end else if (w_adv) begin
                r_a   <= w_a_src[k] >> SEG;
                r_b   <= w_b_src[k] >> SEG;
                r_res <= w_res_cat[WIDTH+SEG-1:SEG];
                r_cy  <= w_cout;
                r_vld <= w_v_src[k];
`ifdef ADDER_OVERFLOW_EN
                r_sa  <= w_sa_src[k];
                r_sb  <= w_sb_src[k];
`endif
            end
        end

        assign w_a_src[k+1] = r_a;
        assign w_b_src[k+1] = r_b;
        assign w_r_src[k+1] = r_res;
        assign w_c_src[k+1] = r_cy;
        assign w_v_src[k+1] = r_vld;
`ifdef ADDER_OVERFLOW_EN
        assign w_sa_src[k+1] = r_sa;
        assign w_sb_src[k+1] = r_sb;
`endif
    end

    // Operand bits are fully consumed by the last stage.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_a_src[STAGES], w_b_src[STAGES]};

    assign out_valid = w_v_src[STAGES];
    assign S         = w_r_src[STAGES];
    assign carryout  = w_c_src[STAGES];

`ifdef ADDER_OVERFLOW_EN
    assign overflow = (w_sa_src[STAGES] == w_sb_src[STAGES]) &&
                      (S[WIDTH-1] != w_sa_src[STAGES]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Scoreboard bench for pipelined_adder with a plain-arithmetic
//            reference model; define ADDER_OVERFLOW_EN to cover overflow.
// Revision : 1.0
// ============================================================================
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SEG    = 8;
    localparam int unsigned STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             carryout;
`ifdef ADDER_OVERFLOW_EN
    logic             overflow;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    pipelined_adder #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .carryout  (carryout)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer arithmetic on the operands, not the datapath.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sb);
        exp_t           e;
        logic [WIDTH:0] u;
        longint         r;
        longint         lim;
        lim = longint'(1) <<< (WIDTH - 1);
        if (!sb) begin
            u    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
            e.co = u[WIDTH];
            r    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end else begin
            u    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
            e.co = !u[WIDTH];
            r    = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
        end
        e.s   = u[WIDTH-1:0];
        e.ov  = (r >= lim) || (r < -lim);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on each output handshake and checks that a
    // stalled output holds steady.
    logic [WIDTH-1:0] hold_s;
    logic             hold_co;
    bit               held = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_S", 64'(S), 64'(hold_s));
                check("hold_carry", 64'(carryout), 64'(hold_co));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got S=0x%0h, expected no output (cycle %0d)", S, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("S", 64'(S), 64'(e.s));
                    check("carryout", 64'(carryout), 64'(e.co));
`ifdef ADDER_OVERFLOW_EN
                    check("overflow", 64'(overflow), 64'(e.ov));
`endif
                    if (e.lat) check("latency", 64'(cyc - e.acc), 64'(STAGES));
                end
            end
            held    <= out_valid && !out_ready;
            hold_s  <= S;
            hold_co <= carryout;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input bit lat);
        int   n;
        exp_t e;
        n        = 0;
        A        = a;
        B        = b;
        Cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
        end else begin
            e     = model(a, b, ci, sb);
            e.acc = cyc;
            e.lat = lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending beats, expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_S", 64'(S), 64'd0);
        check("reset_carryout", 64'(carryout), 64'd0);
`ifdef ADDER_OVERFLOW_EN
        check("reset_overflow", 64'(overflow), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases, back to back with no stall.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
        drain();

        // Sixteen back-to-back random beats at full throughput.
        for (int i = 0; i < 16; i++)
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
        drain();

        // Two beats in flight, output held off for five cycles.
        send(pick(), pick(), 1'b0, 1'b0, 1'b0);
        send(pick(), pick(), 1'b1, 1'b1, 1'b0);
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: none of them may ever emerge.
        for (int i = 0; i < 3; i++)
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_S", 64'(S), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("rst_next_out_valid", 64'(out_valid), 64'd0);
        check("rst_next_carryout", 64'(carryout), 64'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
        drain();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor that splits the carry chain into SEG-bit segments, one register stage per segment. It is the successor to the team's fixed 8-bit ripple adder and serves as the arithmetic unit for datapaths wider than a single-cycle ripple chain can close timing on. Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake after a fixed latency, and the block sustains one operation per cycle when there is no backpressure.

## Interface
- WIDTH, 32, operand and result width; must be a positive multiple of SEG
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts the beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: A+B+Cin; 1: A-B-Cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- S  output  WIDTH  sum/difference
- carryout  output  1  raw carry out of bit WIDTH-1 (sub: 1 = no borrow)
- overflow  output  1  signed overflow; present only with ADDER_OVERFLOW_EN

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Every stage register loads only when adv is high and holds otherwise.
- Input transform: Beff = sub ? ~B : B, c0 = sub ? ~Cin : Cin. Stage k (0..STAGES-1) adds Aeff[k*SEG +: SEG] + Beff[k*SEG +: SEG] + carry from stage k-1, with c0 feeding stage 0.
- Stage k registers: its SEG-bit result, its carry, the not-yet-consumed upper operand bits, the already-computed lower result bits, a valid bit, and (with the macro) the operand sign bits.
- A beat is captured when in_valid && in_ready. A bubble (in_valid low while adv is high) propagates as valid=0.
- S, carryout and overflow come from the last stage registers. They are meaningful only while out_valid=1.
- Arithmetic is modulo 2^WIDTH. Worked cases: 0xFFFFFFFF+0x00000001+0 gives S=0, carryout=1. 5-7 with Cin=0 gives S=0xFFFFFFFE, carryout=0.
- Simultaneous accept and drain in the same cycle is legal and gives full throughput.
- Reset: asynchronous clear of all valid bits and data registers. Reset values: in_ready=1, out_valid=0, S=0, carryout=0, overflow=0. Beats in flight during reset are discarded and never emitted.

## Timing
- Latency is STAGES cycles from the accept edge to out_valid, measured with no stall. Example: WIDTH=32, SEG=8 gives 4 cycles.
- Throughput is 1 beat per cycle while out_ready=1.
- out_valid && !out_ready freezes the whole pipeline. S and carryout stay stable until the handshake completes. in_ready drops in the same cycle, combinationally from out_ready.
- The critical path is one SEG-bit ripple plus the register setup time. There is no combinational path from A/B to S.

## Configuration
- ADDER_OVERFLOW_EN defined: the overflow port exists and the sign bits are pipelined. overflow = (Aeff[msb] == Beff[msb]) && (S[msb] != Aeff[msb]), valid alongside S.
- ADDER_OVERFLOW_EN undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- adder_pkg holds the WIDTH/SEG defaults, the STAGES computation, and an elaboration check that WIDTH % SEG == 0.
- Sub-module adder_segment is a combinational SEG-bit ripple slice built from the existing full_adder cell, with ports a, b, cin, s, cout. It is instantiated once per stage inside a generate loop.

## Test plan
- WIDTH=32, SEG=8, out_ready=1: A=0xFFFFFFFF, B=1, Cin=0, sub=0 gives out_valid 4 cycles later, S=0x00000000, carryout=1.
- sub=1, A=5, B=7, Cin=0 gives S=0xFFFFFFFE, carryout=0. A=7, B=5, Cin=1 gives S=1, carryout=1.
- 16 back-to-back random beats with out_ready=1 give 16 consecutive out_valid cycles in order, each matching the reference model.
- Hold out_ready=0 for 5 cycles with 2 beats in flight: in_ready=0, S stays stable, no beat is lost or duplicated after release.
- Assert rst with 3 beats in flight: the next cycle has out_valid=0, S=0, in_ready=1, and no stale beats ever appear.
- With ADDER_OVERFLOW_EN: 0x7FFFFFFF+1 gives overflow=1. 0x80000000-1 gives overflow=1. 3+4 gives overflow=0.
